ucode_sequencer: RTL
====================

# ucode_sequencer

Micro-sequencer that drives the 9-bit micro-address of `microcode_mod` and qualifies its 65-bit control word for the CPU datapath. It fetches opcode bytes over the memory handshake and dispatches plain and CB-prefixed opcodes to their first microinstruction. It walks each microinstruction chain via the control word's next-address field and stalls on memory micro-ops. It also handles the HALT state and interrupt entry at instruction boundaries. It sits between the memory interface, `microcode_mod` and the datapath register/ALU controls.

## Interface
Parameters:
- `IRQ_UADDR`, 9'h1B0, micro-address of the interrupt-entry routine.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `uaddr`  out  9  micro-address to `microcode_mod.opcode`
- `ctrl`  in  65  control word from `microcode_mod`
- `exec_en`  out  1  datapath may commit `ctrl` this cycle
- `fetch_req`  out  1  opcode-byte read request at PC
- `mem_req`  out  1  micro-op memory access request
- `mem_we`  out  1  write qualifier for `mem_req`
- `mem_ack`  in  1  memory completes current request this cycle
- `mem_rdata`  in  8  read data, valid when `mem_ack`=1
- `pc_inc`  out  1  one-cycle pulse: datapath increments PC
- `irq_pending`  in  1  any enabled interrupt flag set
- `ime`  in  1  interrupt master enable
- `irq_taken`  out  1  one-cycle pulse on interrupt entry
- `halted`  out  1  core in HALT
- `instr_done`  out  1  pulse on the commit cycle of an END microinstruction

## Operation
- Control-word fields: `CW_NEXT`=[8:0] (next micro-address), `CW_END`=[9], `CW_MEM`=[10], `CW_MEMWE`=[11], `CW_HALT`=[12]. Bits [64:13] belong to the datapath and are ignored here.
- States: FETCH, FETCH_CB, EXEC, HALT.
- FETCH: `fetch_req`=1 until `mem_ack`. On the ack cycle:
  - `pc_inc`=1.
  - If `mem_rdata`≠8'hCB: `uaddr`←{1'b0,`mem_rdata`}, next state EXEC.
  - Otherwise next state FETCH_CB.
- FETCH_CB: same handshake and `pc_inc`. On ack, `uaddr`←{1'b1,`mem_rdata`}, next state EXEC. 8'hCB in this state is an ordinary CB opcode and is not re-prefixed.
- EXEC, with `CW_MEM`=0: `exec_en`=1 for one cycle, then advance.
- EXEC, with `CW_MEM`=1: `mem_req`=1 and `mem_we`=`CW_MEMWE`, held stable. `exec_en`=0 until the `mem_ack` cycle, in which `exec_en`=1.
- Advance on the commit cycle:
  - `CW_END`=0: `uaddr`←`CW_NEXT`.
  - `CW_END`=1: `instr_done`=1, then:
    - `CW_HALT`=1 → HALT.
    - else `irq_pending`&`ime` → `uaddr`←`IRQ_UADDR`, `irq_taken`=1, stay in EXEC.
    - else → FETCH.
- HALT: `halted`=1, all requests low. When `irq_pending`=1:
  - `ime`=1 → `uaddr`←`IRQ_UADDR`, `irq_taken`=1, EXEC.
  - `ime`=0 → FETCH.
- `mem_ack` received with no request outstanding is ignored.
- `fetch_req` and `mem_req` are never asserted together.

## Timing
- Reset values: state=FETCH, `uaddr`=0, all outputs 0. The first `fetch_req` appears in the first cycle after `rst_n` rises.
- `rst_n` low mid-fetch or mid-memory-op drops every request at that edge. No partial commit.
- `microcode_mod` is combinational, so `ctrl` corresponds to `uaddr` in the same cycle.
- Zero-wait memory: fetch takes 1 cycle, each non-mem microinstruction 1 cycle, each mem microinstruction 1 cycle.
- Minimum instruction: NOP (single END microinstruction) takes 2 cycles. A CB-prefixed instruction adds 1 cycle plus memory wait.
- The interrupt check samples `irq_pending`/`ime` only on the END commit cycle or in HALT. A mid-instruction change has no effect.
- `uaddr` is registered and changes only on commit or fetch-ack edges.

## Structure
- Shared package `ucode_pkg`: CW_* bit positions, state enum, `IRQ_UADDR` default, 8'hCB prefix constant. `microcode_mod` and the datapath import the same field definitions.
- No sub-modules. One state register, one `uaddr` register, with combinational output decode. `microcode_mod` is instantiated by the parent, not inside this block.

## Test plan
- Reset then NOP: ack with rdata 8'h00 → `uaddr`=9'h000, END commit, `instr_done` pulse, back in FETCH 2 cycles after the ack.
- CB prefix: fetch 8'hCB then 8'h37 → two `pc_inc` pulses, `uaddr`=9'h137. A second byte of 8'hCB → `uaddr`=9'h1CB.
- Memory wait: microinstruction with `CW_MEM`=1, `CW_MEMWE`=1, ack after 3 cycles → `mem_req`/`mem_we` high for 4 cycles, `exec_en` only on the ack cycle, then `uaddr`=`CW_NEXT`.
- Interrupt at boundary: `irq_pending`=1, `ime`=1 raised mid-chain → no effect until the END commit. Then `irq_taken` pulses and `uaddr`=9'h1B0, with no `fetch_req` in between.
- HALT: END with `CW_HALT`=1 → `halted`=1. `irq_pending`=1 with `ime`=0 → FETCH next cycle, `irq_taken`=0. With `ime`=1 → `uaddr`=9'h1B0.
- Reset mid-op: `rst_n`=0 during a `mem_req` wait → all outputs 0 at the next edge, then restart at FETCH.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared microcode definitions: control-word fields, sequencer states
// and fixed micro-addresses used by the sequencer, microcode ROM and datapath.
package ucode_pkg;

  localparam int CW_W       = 65;
  localparam int CW_NEXT_LO = 0;
  localparam int CW_NEXT_HI = 8;
  localparam int CW_END     = 9;
  localparam int CW_MEM     = 10;
  localparam int CW_MEMWE   = 11;
  localparam int CW_HALT    = 12;

  localparam logic [8:0] IRQ_UADDR_DEF = 9'h1B0;
  localparam logic [7:0] CB_PREFIX     = 8'hCB;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_FETCH_CB = 2'd1,
    ST_EXEC     = 2'd2,
    ST_HALT     = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ucode_sequencer.sv
// Micro-sequencer: opcode fetch/dispatch, microinstruction chaining,
// memory micro-op stalls, HALT and interrupt entry at instruction boundaries.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter logic [8:0] IRQ_UADDR = IRQ_UADDR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [8:0]      uaddr,
  input  logic [CW_W-1:0] ctrl,
  output logic            exec_en,
  output logic            fetch_req,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic            pc_inc,
  input  logic            irq_pending,
  input  logic            ime,
  output logic            irq_taken,
  output logic            halted,
  output logic            instr_done
);

  seq_state_e state_q, state_d;
  logic [8:0] uaddr_q, uaddr_d;
  logic       commit;

  logic unused_ctrl;
  assign unused_ctrl = ^ctrl[CW_W-1:CW_HALT+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      uaddr_q <= 9'h000;
    end else begin
      state_q <= state_d;
      uaddr_q <= uaddr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    uaddr_d    = uaddr_q;
    commit     = 1'b0;
    exec_en    = 1'b0;
    fetch_req  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_inc     = 1'b0;
    irq_taken  = 1'b0;
    halted     = 1'b0;
    instr_done = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (mem_ack) begin
          pc_inc = 1'b1;
          if (mem_rdata != CB_PREFIX) begin
            uaddr_d = {1'b0, mem_rdata};
            state_d = ST_EXEC;
          end else begin
            state_d = ST_FETCH_CB;
          end
        end
      end
      ST_FETCH_CB: begin
        fetch_req = 1'b1;
        if (mem_ack) begin
          pc_inc  = 1'b1;
          uaddr_d = {1'b1, mem_rdata};
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctrl[CW_MEM]) begin
          mem_req = 1'b1;
          mem_we  = ctrl[CW_MEMWE];
          commit  = mem_ack;
        end else begin
          commit  = 1'b1;
        end
        exec_en = commit;
        if (commit) begin
          if (!ctrl[CW_END]) begin
            uaddr_d = ctrl[CW_NEXT_HI:CW_NEXT_LO];
          end else begin
            instr_done = 1'b1;
            if (ctrl[CW_HALT]) begin
              state_d = ST_HALT;
            end else if (irq_pending && ime) begin
              uaddr_d   = IRQ_UADDR;
              irq_taken = 1'b1;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (irq_pending) begin
          if (ime) begin
            uaddr_d   = IRQ_UADDR;
            irq_taken = 1'b1;
            state_d   = ST_EXEC;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_FETCH;
    endcase

    // Outputs stay quiet for the whole reset cycle, not just after the edge.
    if (!rst_n) begin
      exec_en    = 1'b0;
      fetch_req  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_inc     = 1'b0;
      irq_taken  = 1'b0;
      halted     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign uaddr = uaddr_q;

endmodule
